// File: rtl/tx_fifo_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_fifo_ctrl_pkg : shared TX sizing constants and arbiter state type. Rev 1.0
// ---------------------------------------------------------------------------
package tx_fifo_ctrl_pkg;

   localparam int TX_DEPTH             = 8;
   localparam int NBYTES               = 8;
   localparam int TX_FIFO_AFULL_MARGIN = 2;

   // Identifies which requester owned the most recent write grant.
   typedef enum logic {
      ARB_REQ0 = 1'b0,
      ARB_REQ1 = 1'b1
   } arb_sel_e;

endpackage
`default_nettype wire

// File: rtl/tx_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_rr_arb2 : two-way round-robin arbiter with registered last-grant. Rev 1.0
// ---------------------------------------------------------------------------
module tx_rr_arb2
   import tx_fifo_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_req0,
   input  logic i_req1,
   output logic o_gnt0,
   output logic o_gnt1
);

   arb_sel_e r_last_gnt;
   logic     w_gnt0;
   logic     w_gnt1;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (i_en) begin
         if (i_req0 && i_req1) begin
            if (r_last_gnt == ARB_REQ1) begin
               w_gnt0 = 1'b1;
            end else begin
               w_gnt1 = 1'b1;
            end
         end else begin
            w_gnt0 = i_req0;
            w_gnt1 = i_req1;
         end
      end
   end

   // Starting from REQ1 lets requester 0 win the first contested cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_gnt <= ARB_REQ1;
      end else if (w_gnt0) begin
         r_last_gnt <= ARB_REQ0;
      end else if (w_gnt1) begin
         r_last_gnt <= ARB_REQ1;
      end
   end

   assign o_gnt0 = w_gnt0;
   assign o_gnt1 = w_gnt1;

endmodule
`default_nettype wire

// File: rtl/tx_fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_fifo_ctrl : TX FIFO pointer, flag and write-port arbitration control. Rev 1.0
// ---------------------------------------------------------------------------
module tx_fifo_ctrl
   import tx_fifo_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH   = TX_DEPTH,
   parameter int DATA_WIDTH   = NBYTES,
   parameter int AFULL_THRESH = FIFO_DEPTH - TX_FIFO_AFULL_MARGIN
)(
   input  logic                          w_clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          req0,
   input  logic [DATA_WIDTH-1:0]         data0,
   output logic                          gnt0,
   input  logic                          req1,
   input  logic [DATA_WIDTH-1:0]         data1,
   output logic                          gnt1,
   input  logic                          r_en,
   output logic                          mem_w_en,
   output logic [$clog2(FIFO_DEPTH)-1:0] mem_w_addr,
   output logic [DATA_WIDTH-1:0]         mem_w_data,
   output logic [$clog2(FIFO_DEPTH)-1:0] mem_r_addr,
   output logic                          empty,
   output logic                          full,
   output logic                          afull,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          ovf_err,
   output logic                          udf_err
);

   localparam int            AW          = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   C_PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   C_AFULL_LVL = (AW+1)'(AFULL_THRESH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_ovf_err;
   logic        r_udf_err;

   logic        w_empty;
   logic        w_full;
   logic [AW:0] w_count;
   logic        w_eligible;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_push;
   logic        w_pop;

   // Extra MSB on each pointer separates the full and empty cases.
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_count    = r_wr_ptr - r_rd_ptr;
   assign w_eligible = !w_full && !flush && !rst;

   tx_rr_arb2 u_arb (
      .clk    (w_clk),
      .rst    (rst),
      .i_en   (w_eligible),
      .i_req0 (req0),
      .i_req1 (req1),
      .o_gnt0 (w_gnt0),
      .o_gnt1 (w_gnt1)
   );

   assign w_push = w_gnt0 | w_gnt1;
   assign w_pop  = r_en && !w_empty && !flush;

   always_ff @(posedge w_clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ovf_err <= 1'b0;
         r_udf_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         // Flush drops everything written so far, including this cycle's pop.
         if (flush) begin
            r_rd_ptr <= r_wr_ptr;
         end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         if ((req0 || req1) && w_full) begin
            r_ovf_err <= 1'b1;
         end
         if (r_en && w_empty) begin
            r_udf_err <= 1'b1;
         end
      end
   end

   assign gnt0       = w_gnt0;
   assign gnt1       = w_gnt1;
   assign mem_w_en   = w_push;
   assign mem_w_addr = r_wr_ptr[AW-1:0];
   assign mem_w_data = w_gnt1 ? data1 : data0;
   assign mem_r_addr = r_rd_ptr[AW-1:0];
   assign empty      = w_empty;
   assign full       = w_full;
   assign afull      = (w_count >= C_AFULL_LVL);
   assign count      = w_count;
   assign ovf_err    = r_ovf_err;
   assign udf_err    = r_udf_err;

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tx_fifo_ctrl : directed vector bench for tx_fifo_ctrl with storage model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_tx_fifo_ctrl;

   localparam int DEPTH = 8;
   localparam int DW    = 8;

   logic          w_clk = 1'b0;
   logic          rst, flush, req0, req1, r_en;
   logic [DW-1:0] data0, data1;
   logic          gnt0, gnt1, mem_w_en, empty, full, afull, ovf_err, udf_err;
   logic [2:0]    mem_w_addr, mem_r_addr;
   logic [DW-1:0] mem_w_data;
   logic [3:0]    count;
   logic [DW-1:0] mem [0:DEPTH-1];
   logic [DW-1:0] r_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 w_clk = ~w_clk;

   tx_fifo_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_THRESH(6)) dut (
      .w_clk(w_clk), .rst(rst), .flush(flush),
      .req0(req0), .data0(data0), .gnt0(gnt0),
      .req1(req1), .data1(data1), .gnt1(gnt1),
      .r_en(r_en), .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr),
      .mem_w_data(mem_w_data), .mem_r_addr(mem_r_addr),
      .empty(empty), .full(full), .afull(afull), .count(count),
      .ovf_err(ovf_err), .udf_err(udf_err)
   );

   // Storage array stand-in: registered write, combinational read.
   always @(posedge w_clk) if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
   assign r_data = mem[mem_r_addr];

   typedef struct {
      logic       rst, req0, req1, ren, fl;
      logic [7:0] d0, d1;
      logic [25:0] exp_st;
      logic       exp_emp;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t tbl [24];

   function automatic vec_t mk(input logic rs, r0, input logic [7:0] d0v,
                               input logic r1, input logic [7:0] d1v,
                               input logic ren, fl, g0, g1, input logic [2:0] wa,
                               input logic [7:0] wd, input logic [2:0] ra,
                               input logic [3:0] cnt, input logic emp, fu, af, ov, ud,
                               input logic [7:0] rd);
      vec_t v;
      v.rst = rs; v.req0 = r0; v.d0 = d0v; v.req1 = r1; v.d1 = d1v;
      v.ren = ren; v.fl = fl;
      v.exp_st  = {g0, g1, g0 | g1, wa, wd, ra, cnt, emp, fu, af, ov, ud};
      v.exp_emp = emp;
      v.exp_rd  = rd;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic [7:0] d0v, input logic r1,
                        input logic [7:0] d1v, input logic ren, input logic fl);
      req0 = r0; data0 = d0v; req1 = r1; data1 = d1v; r_en = ren; flush = fl;
   endtask

   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 8'h00, 0, 8'h00, 0, 0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [7:0] q[$];
   logic [7:0] alt_exp [4];

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      rst = 1'b1;
      drive(0, 8'h00, 0, 8'h00, 0, 0);
      #1;
      do_reset();

      // ---------------- table-driven main sequence ----------------
      tbl[0]  = mk(1,1,8'hFF,1,8'hEE,0,0, 0,0,3'd0,8'hFF,3'd0,4'd0,1,0,0,0,0,8'h00);
      tbl[1]  = mk(0,0,8'h00,0,8'h00,0,0, 0,0,3'd0,8'h00,3'd0,4'd0,1,0,0,0,0,8'h00);
      for (int i = 0; i < 8; i++)
         tbl[2+i] = mk(0,1,8'hA0+8'(i),0,8'h00,0,0, 1,0,3'(i),8'hA0+8'(i),3'd0,4'(i),
                       (i == 0),0,(i >= 6),0,0,8'hA0);
      tbl[10] = mk(0,1,8'hA8,0,8'h00,0,0, 0,0,3'd0,8'hA8,3'd0,4'd8,0,1,1,0,0,8'hA0);
      tbl[11] = mk(0,0,8'h00,0,8'h00,0,0, 0,0,3'd0,8'h00,3'd0,4'd8,0,1,1,1,0,8'hA0);
      tbl[12] = mk(0,0,8'h00,1,8'hB0,1,0, 0,0,3'd0,8'h00,3'd0,4'd8,0,1,1,1,0,8'hA0);
      tbl[13] = mk(0,0,8'h00,1,8'hB0,0,0, 0,1,3'd0,8'hB0,3'd1,4'd7,0,0,1,1,0,8'hA1);
      tbl[14] = mk(0,0,8'h00,0,8'h00,1,0, 0,0,3'd1,8'h00,3'd1,4'd8,0,1,1,1,0,8'hA1);
      for (int j = 0; j < 6; j++)
         tbl[15+j] = mk(0,0,8'h00,0,8'h00,1,0, 0,0,3'd1,8'h00,3'(2+j),4'(7-j),
                        0,0,(j < 2),1,0,8'hA2+8'(j));
      tbl[21] = mk(0,0,8'h00,0,8'h00,1,0, 0,0,3'd1,8'h00,3'd0,4'd1,0,0,0,1,0,8'hB0);
      tbl[22] = mk(0,1,8'hC0,0,8'h00,1,0, 1,0,3'd1,8'hC0,3'd1,4'd0,1,0,0,1,0,8'h00);
      tbl[23] = mk(0,0,8'h00,0,8'h00,0,0, 0,0,3'd2,8'h00,3'd1,4'd1,0,0,0,1,1,8'hC0);

      for (int i = 0; i < 24; i++) begin
         rst = tbl[i].rst;
         drive(tbl[i].req0, tbl[i].d0, tbl[i].req1, tbl[i].d1, tbl[i].ren, tbl[i].fl);
         #2;
         check($sformatf("vec%0d_status", i),
               64'({gnt0, gnt1, mem_w_en, mem_w_addr, mem_w_data, mem_r_addr,
                    count, empty, full, afull, ovf_err, udf_err}),
               64'(tbl[i].exp_st));
         if (!tbl[i].exp_emp) check($sformatf("vec%0d_rdata", i), 64'(r_data), 64'(tbl[i].exp_rd));
         tick();
      end
      rst = 1'b0;

      // ---------------- contested arbitration from reset ----------------
      do_reset();
      begin
         int k0, k1;
         k0 = 0; k1 = 0;
         for (int c = 0; c < 4; c++) begin
            drive(1, 8'h00 + 8'(k0), 1, 8'h10 + 8'(k1), 0, 0);
            #2;
            check($sformatf("alt%0d_gnt", c), 64'({gnt0, gnt1}), (c % 2 == 0) ? 64'h2 : 64'h1);
            if (c % 2 == 0) k0++; else k1++;
            tick();
         end
      end
      alt_exp[0] = 8'h00; alt_exp[1] = 8'h10; alt_exp[2] = 8'h01; alt_exp[3] = 8'h11;
      for (int c = 0; c < 4; c++) begin
         drive(0, 8'h00, 0, 8'h00, 1, 0);
         #2;
         check($sformatf("alt_pop%0d_rdata", c), 64'(r_data), 64'(alt_exp[c]));
         tick();
      end
      drive(0, 8'h00, 0, 8'h00, 0, 0);
      #2;
      check("alt_drained_empty", 64'(empty), 64'h1);

      // ---------------- fill 5, stream 6 across the wrap ----------------
      do_reset();
      q.delete();
      for (int i = 0; i < 5; i++) begin
         drive(1, 8'h50 + 8'(i), 0, 8'h00, 0, 0);
         tick();
         q.push_back(8'h50 + 8'(i));
      end
      for (int k = 0; k < 6; k++) begin
         drive(0, 8'h00, 1, 8'h60 + 8'(k), (k < 5), 0);
         #2;
         check($sformatf("wrap%0d_count", k), 64'(count), 64'(q.size()));
         check($sformatf("wrap%0d_rdata", k), 64'(r_data), 64'(q[0]));
         check($sformatf("wrap%0d_gnt1", k), 64'(gnt1), 64'h1);
         tick();
         if (k < 5) void'(q.pop_front());
         q.push_back(8'h60 + 8'(k));
      end
      while (q.size() > 0) begin
         drive(0, 8'h00, 0, 8'h00, 1, 0);
         #2;
         check("drain_count", 64'(count), 64'(q.size()));
         check("drain_empty", 64'(empty), 64'h0);
         check("drain_rdata", 64'(r_data), 64'(q[0]));
         tick();
         void'(q.pop_front());
      end
      drive(0, 8'h00, 0, 8'h00, 0, 0);
      #2;
      check("drain_final_empty", 64'({empty, count}), 64'h10);

      // ---------------- flush, underflow stickiness, reset ----------------
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 8'h70 + 8'(i), 0, 8'h00, 0, 0);
         tick();
      end
      drive(1, 8'h7F, 0, 8'h00, 1, 1);
      #2;
      check("flush_no_gnt", 64'({gnt0, mem_w_en}), 64'h0);
      check("flush_pre_count", 64'(count), 64'd3);
      tick();
      drive(0, 8'h00, 0, 8'h00, 0, 0);
      #2;
      check("flush_post", 64'({empty, count}), 64'h10);
      drive(0, 8'h00, 0, 8'h00, 1, 0);
      #2;
      check("udf_before_edge", 64'(udf_err), 64'h0);
      tick();
      drive(0, 8'h00, 0, 8'h00, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #2;
         check($sformatf("udf_sticky%0d", i), 64'({udf_err, empty}), 64'h3);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      check("post_rst_flags", 64'({udf_err, ovf_err, empty, count}), 64'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tx_fifo_ctrl.md
Name: tx_fifo_ctrl

Overview:
Single-clock pointer and arbitration controller for the TX FIFO storage array. Shares the array's single write port between two requesters (data path 0 = protocol-layer flits, 1 = retry/replay path) with round-robin arbitration. Generates write enable/address/data and read address, and tracks occupancy, full/empty, almost-full and error flags for the TX datapath. The storage array itself stays a separate instance; this block only drives its w_en/w_addr/w_data/r_addr and passes r_data through.

Parameters:
FIFO_DEPTH, `TX_DEPTH, number of entries; must be a power of 2, >= 4
DATA_WIDTH, `NBYTES, entry width in bits
AFULL_THRESH, FIFO_DEPTH-2, count at or above which afull asserts
AW, $clog2(FIFO_DEPTH), address width (derived, not overridden)

Ports:
w_clk  input  1  single clock for all logic
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous clear of FIFO contents (pointers only)
req0  input  1  requester 0 write request
data0  input  DATA_WIDTH  requester 0 write data
gnt0  output  1  requester 0 write accepted this cycle
req1  input  1  requester 1 write request
data1  input  DATA_WIDTH  requester 1 write data
gnt1  output  1  requester 1 write accepted this cycle
r_en  input  1  consumer pop request
mem_w_en  output  1  write enable to storage array
mem_w_addr  output  AW  write address to storage array
mem_w_data  output  DATA_WIDTH  write data to storage array
mem_r_addr  output  AW  read address to storage array
empty  output  1  no valid entries
full  output  1  FIFO_DEPTH entries held
afull  output  1  count >= AFULL_THRESH
count  output  AW+1  current occupancy
ovf_err  output  1  sticky: request seen while full
udf_err  output  1  sticky: r_en seen while empty

Behaviour:
- Pointers wr_ptr/rd_ptr are AW+1 bits; address = low AW bits; empty = (wr_ptr == rd_ptr); full = MSBs differ and low bits equal. count = wr_ptr - rd_ptr (mod 2^(AW+1)).
- Reset (rst=1 at a w_clk edge): wr_ptr=rd_ptr=0, last_gnt=1 (req0 wins first), ovf_err=udf_err=0. While rst is high, gnt0/gnt1/mem_w_en forced 0. After reset: empty=1, full=0, afull=0, count=0, mem_w_addr=mem_r_addr=0.
- Arbitration (combinational grant, registered state): eligible = !full && !flush && !rst. Only one requester -> it is granted. Both requesting -> grant the one not equal to last_gnt. last_gnt updates only on an actual grant.
- Write: mem_w_en = gnt0|gnt1; mem_w_data = granted requester's data (data0 when neither is granted); mem_w_addr = wr_ptr[AW-1:0]. wr_ptr increments at the edge where mem_w_en=1. Zero-cycle accept: gnt is the handshake, and the requester must hold req/data until it sees gnt.
- Read: mem_r_addr = rd_ptr[AW-1:0]; storage r_data is valid combinationally whenever empty=0. Pop accepted when r_en && !empty && !flush; rd_ptr increments at that edge. Data written at edge N is readable (empty=0) from cycle N+1.
- Simultaneous push+pop: both pointers advance, count unchanged. Push while full is blocked even if pop occurs the same cycle, because full is evaluated on the pre-edge state. Pop while empty is blocked even if a push occurs the same cycle.
- Wrap-around: pointers roll naturally at 2^(AW+1); address wraps from FIFO_DEPTH-1 to 0.
- flush=1: at the edge, rd_ptr <= wr_ptr (FIFO becomes empty); no grants and no pops that cycle. Error flags are not cleared.
- ovf_err sets on any cycle with (req0|req1) && full && !rst. udf_err sets on r_en && empty && !rst. Both are cleared only by rst.
- rst mid-operation discards all contents and pending handshakes; no grant occurs in the reset cycle.

Decomposition:
- Shared TX defines provide TX_DEPTH and NBYTES. Add TX_FIFO_AFULL_MARGIN (default 2) so the threshold is set in one place.
- One natural sub-module: tx_rr_arb2, the 2-way round-robin arbiter (req0/req1, enable, last_gnt state -> gnt0/gnt1).
- Pointer, flag and error logic stays in tx_fifo_ctrl. The bench instantiates tx_fifo_ctrl together with the storage array.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, gnt0=gnt1=0, errors 0.
- DEPTH=8, req0 alone, 8 writes A0..A7 -> gnt0 each cycle, mem_w_addr 0..7, full=1 after the 8th; a 9th req0 -> gnt0=0, ovf_err=1; afull asserts at count=6.
- req0 and req1 both held for 4 cycles from reset -> grants alternate 0,1,0,1; entries land in order D0_0,D1_0,D0_1,D1_1.
- Full FIFO with push and pop in the same cycle -> pop accepted, push blocked, count 8->7; next cycle push accepted -> count 8, wr address wraps to 0.
- Fill to 5, pop 5 while writing 6 more (crossing index 7->0) -> read order preserved, count correct each cycle, empty only when wr_ptr==rd_ptr.
- count=3, assert flush together with req0 and r_en -> no gnt, no pop, next cycle empty=1, count=0; r_en on empty -> udf_err=1 and it stays set until rst.
